ram_clr: RTL and testbench

Parametrised single-port synchronous RAM with a built-in hardware clear engine. It generalises the 256×16 data RAM to any width and depth. It adds a selectable read-during-write mode and a sweep that fills every word with a constant after reset or on request. It sits between the CPU data bus and block RAM, and guarantees defined contents at boot without a software clear loop.

---
 rtl/hack_mem_pkg.sv | 14 +
 rtl/ram_array.sv | 36 +++
 rtl/ram_clr.sv | 86 ++++++++
 tb/tb_ram_clr.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/hack_mem_pkg.sv
// Shared definitions for the Hack data-memory family: controller state
// encoding and the default geometry of the data RAM.
`timescale 1ns/1ps
package hack_mem_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  localparam int HACK_DATA_WIDTH = 16;
  localparam int HACK_ADDR_WIDTH = 8;

endpackage

// File: rtl/ram_array.sv
// Plain single-port synchronous RAM with one write port and a registered,
// enable-gated read port; read-during-write behaviour is set by WRITE_FIRST.
`timescale 1ns/1ps
module ram_array #(
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_WIDTH  = 8,
  parameter bit WRITE_FIRST = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  we,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // NOTE: the array itself has no reset so it maps onto block RAM; only the
  // read register is reset, which keeps the output defined from time zero.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= (WRITE_FIRST && we) ? wdata : mem[addr];
    end
  end

endmodule

// File: rtl/ram_clr.sv
// Single-port RAM with a hardware clear engine that sweeps INIT_VALUE through
// every word after reset (optionally) or on a clear request.
`timescale 1ns/1ps
module ram_clr
  import hack_mem_pkg::*;
#(
  parameter int                   DATA_WIDTH     = HACK_DATA_WIDTH,
  parameter int                   ADDR_WIDTH     = HACK_ADDR_WIDTH,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE    = '0,
  parameter bit                   CLEAR_ON_RESET = 1'b1,
  parameter bit                   WRITE_FIRST    = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] in,
  input  logic                  load,
  input  logic                  clear,
  output logic [DATA_WIDTH-1:0] out,
  output logic                  busy
);

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] ptr, ptr_nxt;

  logic                  mem_we;
  logic                  mem_re;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= CLEAR_ON_RESET ? CLEAR : IDLE;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
    end
  end

  // NOTE: every signal gets a default before the case so no latch is inferred.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    unique case (state)
      IDLE: begin
        if (clear) begin
          state_nxt = CLEAR;
          ptr_nxt   = '0;
        end
      end
      CLEAR: begin
        ptr_nxt = ptr + ADDR_WIDTH'(1);
        if (ptr == {ADDR_WIDTH{1'b1}}) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        ptr_nxt   = '0;
      end
    endcase
  end

  // busy comes straight from the state flop, so no input reaches it combinationally.
  assign busy = (state == CLEAR);

  // The sweep owns the write port while busy; reads are frozen so out holds.
  assign mem_we    = busy ? 1'b1       : load;
  assign mem_addr  = busy ? ptr        : address;
  assign mem_wdata = busy ? INIT_VALUE : in;
  assign mem_re    = ~busy;

  ram_array #(
    .DATA_WIDTH  (DATA_WIDTH),
    .ADDR_WIDTH  (ADDR_WIDTH),
    .WRITE_FIRST (WRITE_FIRST)
  ) u_array (
    .clk   (clk),
    .rst   (reset),
    .addr  (mem_addr),
    .we    (mem_we),
    .wdata (mem_wdata),
    .re    (mem_re),
    .rdata (out)
  );

endmodule

// File: tb/tb_ram_clr.sv
// Directed bench for ram_clr: three instances cover the default read-first
// part, a write-first part with a non-zero fill, and a small idle-at-reset part.
`timescale 1ns/1ps
module tb_ram_clr;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [7:0]  address;
  logic [15:0] in_d;
  logic        load, clear;
  logic [15:0] out0, out1;
  logic        busy0, busy1;

  logic [3:0]  address2;
  logic [7:0]  in2, out2;
  logic        load2, clear2, busy2;

  int passed = 0;
  int total  = 0;
  int n;

  ram_clr #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .INIT_VALUE(16'h0000),
            .CLEAR_ON_RESET(1'b1), .WRITE_FIRST(1'b0)) u0 (
    .clk(clk), .reset(reset), .address(address), .in(in_d), .load(load),
    .clear(clear), .out(out0), .busy(busy0));

  ram_clr #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .INIT_VALUE(16'h00FF),
            .CLEAR_ON_RESET(1'b1), .WRITE_FIRST(1'b1)) u1 (
    .clk(clk), .reset(reset), .address(address), .in(in_d), .load(load),
    .clear(clear), .out(out1), .busy(busy1));

  ram_clr #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .INIT_VALUE(8'h3C),
            .CLEAR_ON_RESET(1'b0), .WRITE_FIRST(1'b0)) u2 (
    .clk(clk), .reset(reset), .address(address2), .in(in2), .load(load2),
    .clear(clear2), .out(out2), .busy(busy2));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; address = '0; in_d = '0; load = 1'b0; clear = 1'b0;
    address2 = '0; in2 = '0; load2 = 1'b0; clear2 = 1'b0;
    repeat (3) tick();

    // Reset state
    check("rst_out0", 32'(out0), 32'h0);
    check("rst_out1", 32'(out1), 32'h0);
    check("rst_busy0", 32'(busy0), 32'h1);
    check("rst_busy1", 32'(busy1), 32'h1);
    check("rst_busy2", 32'(busy2), 32'h0);
    check("rst_out2", 32'(out2), 32'h0);

    // Boot sweep must last exactly 256 edges
    reset = 1'b0;
    n = 0;
    while (busy0 && n < 400) begin tick(); n++; end
    check("boot_len", 32'(n), 32'd256);
    check("boot_busy1", 32'(busy1), 32'h0);
    check("boot_busy2", 32'(busy2), 32'h0);

    address = 8'd0;   tick();
    check("boot_rd0_u0", 32'(out0), 32'h0000);
    check("boot_rd0_u1", 32'(out1), 32'h00FF);
    address = 8'd127; tick();
    check("boot_rd127_u0", 32'(out0), 32'h0000);
    check("boot_rd127_u1", 32'(out1), 32'h00FF);
    address = 8'd255; tick();
    check("boot_rd255_u0", 32'(out0), 32'h0000);
    check("boot_rd255_u1", 32'(out1), 32'h00FF);

    // Write then read, and read-during-write in both modes
    address = 8'h12; in_d = 16'hBEEF; load = 1'b1; tick(); load = 1'b0;
    check("rdw_old_u0", 32'(out0), 32'h0000);
    check("rdw_new_u1", 32'(out1), 32'hBEEF);
    tick();
    check("rd_u0", 32'(out0), 32'hBEEF);
    check("rd_u1", 32'(out1), 32'hBEEF);
    in_d = 16'h1234; load = 1'b1; tick(); load = 1'b0;
    check("rdw2_old_u0", 32'(out0), 32'hBEEF);
    check("rdw2_new_u1", 32'(out1), 32'h1234);
    tick();
    check("rd2_u0", 32'(out0), 32'h1234);
    check("rd2_u1", 32'(out1), 32'h1234);

    // Fill with A5A5, then clear request
    for (int i = 0; i < 256; i++) begin
      address = 8'(i); in_d = 16'hA5A5; load = 1'b1; tick();
    end
    load = 1'b0; address = 8'h40; tick();
    check("fill_u0", 32'(out0), 32'hA5A5);
    check("fill_u1", 32'(out1), 32'hA5A5);

    clear = 1'b1; tick(); clear = 1'b0;
    check("clr_busy0", 32'(busy0), 32'h1);
    check("clr_busy1", 32'(busy1), 32'h1);
    n = 0;
    while (busy1 && n < 400) begin
      load    = (n == 3);
      address = (n == 3) ? 8'h05 : 8'h40;
      in_d    = 16'h1111;
      clear   = (n == 10);
      tick();
      n++;
    end
    load = 1'b0; clear = 1'b0;
    check("clr_len", 32'(n), 32'd256);
    check("clr_hold_u0", 32'(out0), 32'hA5A5);
    check("clr_hold_u1", 32'(out1), 32'hA5A5);
    for (int i = 0; i < 256; i++) begin
      address = 8'(i); tick();
      check($sformatf("sweep_u0[%0d]", i), 32'(out0), 32'h0000);
      check($sformatf("sweep_u1[%0d]", i), 32'(out1), 32'h00FF);
    end
    check("clr_idle_busy", 32'(busy1), 32'h0);

    // Reset in the middle of a sweep
    address = 8'h33; in_d = 16'h7777; load = 1'b1; tick(); load = 1'b0; tick();
    check("pre_u0", 32'(out0), 32'h7777);
    check("pre_u1", 32'(out1), 32'h7777);
    clear = 1'b1; tick(); clear = 1'b0;
    repeat (100) tick();
    check("mid_busy0", 32'(busy0), 32'h1);
    reset = 1'b1; #1;
    check("mid_rst_out0", 32'(out0), 32'h0);
    check("mid_rst_out1", 32'(out1), 32'h0);
    check("mid_rst_busy0", 32'(busy0), 32'h1);
    check("mid_rst_busy1", 32'(busy1), 32'h1);
    check("mid_rst_busy2", 32'(busy2), 32'h0);
    tick(); reset = 1'b0;
    n = 0;
    while (busy0 && n < 400) begin tick(); n++; end
    check("mid_len", 32'(n), 32'd256);
    tick();
    check("mid_rd33_u0", 32'(out0), 32'h0000);
    check("mid_rd33_u1", 32'(out1), 32'h00FF);

    // Small part: 8-bit x 16, idle after reset
    address2 = 4'd15; in2 = 8'hAA; load2 = 1'b1; tick(); load2 = 1'b0; tick();
    check("s_rd15", 32'(out2), 32'hAA);
    clear2 = 1'b1; tick(); clear2 = 1'b0;
    check("s_busy", 32'(busy2), 32'h1);
    n = 0;
    while (busy2 && n < 100) begin tick(); n++; end
    check("s_len", 32'(n), 32'd16);
    check("s_hold", 32'(out2), 32'hAA);
    tick();
    check("s_clr15", 32'(out2), 32'h3C);
    address2 = 4'd0; tick();
    check("s_clr0", 32'(out2), 32'h3C);

    // Second sweep: load alongside clear is overwritten, ptr restarts at 0
    in2 = 8'h55; load2 = 1'b1; clear2 = 1'b1; tick(); load2 = 1'b0; clear2 = 1'b0;
    n = 0;
    while (busy2 && n < 100) begin tick(); n++; end
    check("s_len2", 32'(n), 32'd16);
    tick();
    check("s_clr0_again", 32'(out2), 32'h3C);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
